// File: rtl/deser_pkg.sv
// deser_pkg: shared constants and helpers for the multi-lane deserializer
package deser_pkg;
    localparam int ORDER_LSB = 0;
    localparam int ORDER_MSB = 1;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/deser_lane.sv
// deser_lane: one lane's shift register, exposing the post-shift value
module deser_lane import deser_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = ORDER_LSB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             sdata,
    output logic [WIDTH-1:0] nxt
);
    logic [WIDTH-1:0] q;
    always_comb
        nxt = !shift_en ? q : (MSB_FIRST == ORDER_MSB) ? {q[WIDTH-2:0], sdata} : {sdata, q[WIDTH-1:1]};
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else q <= nxt;
endmodule

// File: rtl/deser_multi_ch.sv
// deser_multi_ch: lock-step multi-lane deserializer with valid/ready output buffer
module deser_multi_ch import deser_pkg::*; #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      shift_en,
    input  logic [NUM_CH-1:0]         sdata,
    input  logic                      auto_latch,
    input  logic                      latch,
    output logic [NUM_CH*WIDTH-1:0]   dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      overrun,
    output logic                      short_frame,
    input  logic                      clr_err,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    logic [NUM_CH*WIDTH-1:0] word;
    logic [CW-1:0] cnt_post;
    logic capture, drop, load, short;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        deser_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
            .clk(clk),
            .reset(reset),
            .shift_en(shift_en),
            .sdata(sdata[i]),
            .nxt(word[lane_lo(i, WIDTH) +: WIDTH])
        );
    end
    // captures use the post-shift word and count so a bit shifted on the capture edge belongs to the word
    always_comb begin
        cnt_post = (shift_en && bit_cnt != FULL) ? bit_cnt + 1'b1 : bit_cnt;
        capture  = auto_latch ? (shift_en && bit_cnt == FULL - 1'b1) : latch;
        drop     = capture && dout_valid && !dout_ready;
        load     = capture && !drop;
        short    = !auto_latch && latch && cnt_post != FULL;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bit_cnt     <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            bit_cnt     <= capture ? '0 : cnt_post;
            short_frame <= short;
            if (load) dout <= word;
            dout_valid  <= load || (dout_valid && !dout_ready);
            overrun     <= drop || (overrun && !clr_err);
        end
endmodule

// File: tb/tb_deser_multi_ch.sv
// tb_deser_multi_ch: directed bench with a bit-history model for both bit orders
module tb_deser_multi_ch;
    localparam int NC = 4;
    localparam int W  = 8;

    logic clk = 0;
    logic reset = 1;
    logic shift_en = 0, auto_latch = 1, latch = 0, dout_ready = 1, clr_err = 0;
    logic [NC-1:0] sdata = '0;
    logic [NC*W-1:0] dout0, dout1;
    logic valid0, valid1, ovr0, ovr1, short0, short1;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    deser_multi_ch #(.NUM_CH(NC), .WIDTH(W), .MSB_FIRST(0)) dut0 (
        .clk(clk), .reset(reset), .shift_en(shift_en), .sdata(sdata),
        .auto_latch(auto_latch), .latch(latch), .dout(dout0), .dout_valid(valid0),
        .dout_ready(dout_ready), .overrun(ovr0), .short_frame(short0),
        .clr_err(clr_err), .bit_cnt(cnt0));

    deser_multi_ch #(.NUM_CH(NC), .WIDTH(W), .MSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .shift_en(shift_en), .sdata(sdata),
        .auto_latch(auto_latch), .latch(latch), .dout(dout1), .dout_valid(valid1),
        .dout_ready(dout_ready), .overrun(ovr1), .short_frame(short1),
        .clr_err(clr_err), .bit_cnt(cnt1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: each lane remembers its last W received bits (oldest first)
    bit hist [NC][$];
    int m_cnt;
    bit m_valid, m_ovr, m_short;
    logic [NC*W-1:0] m_w0, m_w1;

    initial for (int l = 0; l < NC; l++) repeat (W) hist[l].push_back(1'b0);

    always @(posedge clk) begin : model
        int old;
        bit cap, drop;
        if (reset) begin
            for (int l = 0; l < NC; l++) begin
                hist[l].delete();
                repeat (W) hist[l].push_back(1'b0);
            end
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_short = 0; m_w0 = '0; m_w1 = '0;
        end else begin
            if (shift_en)
                for (int l = 0; l < NC; l++) begin
                    hist[l].push_back(sdata[l]);
                    void'(hist[l].pop_front());
                end
            old = m_cnt;
            if (shift_en && m_cnt < W) m_cnt++;
            cap = auto_latch ? (shift_en && old == W - 1) : latch;
            m_short = !auto_latch && latch && m_cnt < W;
            drop = cap && m_valid && !dout_ready;
            if (cap && !drop) begin
                for (int l = 0; l < NC; l++)
                    for (int j = 0; j < W; j++) begin
                        m_w0[l*W + j] = hist[l][j];
                        m_w1[l*W + W - 1 - j] = hist[l][j];
                    end
                m_valid = 1;
            end else if (m_valid && dout_ready) m_valid = 0;
            if (drop) m_ovr = 1;
            else if (clr_err) m_ovr = 0;
            if (cap) m_cnt = 0;
        end
        #1;
        chk("dout0", 64'(dout0), 64'(m_w0));
        chk("dout1", 64'(dout1), 64'(m_w1));
        chk("valid0", 64'(valid0), 64'(m_valid));
        chk("valid1", 64'(valid1), 64'(m_valid));
        chk("overrun0", 64'(ovr0), 64'(m_ovr));
        chk("overrun1", 64'(ovr1), 64'(m_ovr));
        chk("short0", 64'(short0), 64'(m_short));
        chk("short1", 64'(short1), 64'(m_short));
        chk("bit_cnt0", 64'(cnt0), 64'(m_cnt));
        chk("bit_cnt1", 64'(cnt1), 64'(m_cnt));
    end

    task automatic step(input logic se, input logic [NC-1:0] sd, input logic al,
                        input logic lt, input logic rdy, input logic ce);
        shift_en = se; sdata = sd; auto_latch = al; latch = lt; dout_ready = rdy; clr_err = ce;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b3,
                         input int gap, input logic rdy_e, input logic rdy_l);
        for (int i = 0; i < W; i++) begin
            if (i == gap) repeat (3) step(0, 4'hF, 1, 0, rdy_e, 0);
            step(1, {b3[i], 1'b0, b1[i], b0[i]}, 1, 0, (i == W - 1) ? rdy_l : rdy_e, 0);
        end
    endtask

    task automatic idle();
        step(0, 4'h0, 1, 0, 1, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", 64'(dout0), 64'h0);
        chk("rst_valid", 64'(valid0), 64'h0);
        chk("rst_cnt", 64'(cnt0), 64'h0);
        chk("rst_ovr", 64'(ovr0), 64'h0);
        reset = 0;

        frame(8'hA5, 8'h0F, 8'h81, 99, 1, 1);
        chk("a_lane0", 64'(dout0[7:0]), 64'hA5);
        chk("a_lane1_lsb", 64'(dout0[15:8]), 64'h0F);
        chk("a_lane1_msb", 64'(dout1[15:8]), 64'hF0);
        chk("a_lane3_msb", 64'(dout1[31:24]), 64'h81);
        chk("a_valid", 64'(valid0), 64'h1);
        chk("a_cnt", 64'(cnt0), 64'h0);
        idle();
        chk("a_valid_drop", 64'(valid0), 64'h0);

        frame(8'h5A, 8'h33, 8'h81, 3, 1, 1);
        chk("b_lane0", 64'(dout0[7:0]), 64'h5A);
        chk("b_lane1_msb", 64'(dout1[15:8]), 64'hCC);
        chk("b_lane3_msb", 64'(dout1[31:24]), 64'h81);
        idle();

        repeat (5) step(1, 4'h1, 0, 0, 1, 0);
        chk("c_cnt5", 64'(cnt0), 64'h5);
        step(0, 4'h0, 0, 1, 1, 0);
        chk("c_short", 64'(short0), 64'h1);
        chk("c_valid", 64'(valid0), 64'h1);
        chk("c_stale", 64'(dout0[7:0]), 64'hFA);
        idle();
        chk("c_short_pulse", 64'(short0), 64'h0);
        for (int i = 0; i < W; i++) begin
            logic [7:0] b;
            b = 8'hC3;
            step(1, {3'b0, b[i]}, 0, i == W - 1, 1, 0);
        end
        chk("c_full_short", 64'(short0), 64'h0);
        chk("c_full_word", 64'(dout0[7:0]), 64'hC3);
        idle();

        frame(8'h11, 8'h00, 8'h00, 99, 0, 0);
        chk("d_first", 64'(dout0[7:0]), 64'h11);
        frame(8'h22, 8'h00, 8'h00, 99, 0, 0);
        chk("d_held", 64'(dout0[7:0]), 64'h11);
        chk("d_overrun", 64'(ovr0), 64'h1);
        step(0, 4'h0, 1, 0, 0, 1);
        chk("d_clr", 64'(ovr0), 64'h0);
        frame(8'h22, 8'h00, 8'h00, 99, 0, 1);
        chk("d_same_edge", 64'(dout0[7:0]), 64'h22);
        chk("d_same_valid", 64'(valid0), 64'h1);
        chk("d_same_ovr", 64'(ovr0), 64'h0);
        idle();

        repeat (4) step(1, 4'hF, 1, 0, 1, 0);
        reset = 1;
        #1;
        chk("e_rst_dout", 64'(dout0), 64'h0);
        chk("e_rst_cnt", 64'(cnt0), 64'h0);
        chk("e_rst_valid", 64'(valid0), 64'h0);
        @(negedge clk);
        reset = 0;
        frame(8'h3C, 8'h00, 8'h00, 99, 1, 1);
        chk("e_word0", 64'(dout0), 64'h3C);
        chk("e_word1", 64'(dout1), 64'h3C);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
